adder4_seq: RTL and testbench



---
 rtl/adder4_seq.sv | 112 +++++++++++
 tb/tb_adder4_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/adder4_seq.sv
// Multi-precision adder sequencer: one 4-bit slice, one nibble per clock, LSB first.
// Optional subtract mode enabled by defining ADDSEQ_SUB_EN.
module adder4_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   cin,
`ifdef ADDSEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   S,
    output logic                   cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               c_q, c_d;
    logic [W-1:0]       s_q, s_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [4:0]         sum5;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        s_d     = s_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        sum5    = {1'b0, a_q[{idx_q, 2'b00} +: 4]} + {1'b0, b_q[{idx_q, 2'b00} +: 4]}
                + {4'b0000, c_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = cin;
`ifdef ADDSEQ_SUB_EN
                    // Two's-complement subtract: A + ~B + 1, cout doubles as "no borrow".
                    if (sub) begin
                        b_d = ~B;
                        c_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[{idx_q, 2'b00} +: 4] = sum5[3:0];
                c_d   = sum5[4];
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    cout_d  = sum5[4];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    // Operand latches are only read in RUN after an accept loads them, so no reset needed.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign S    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder4_seq.sv
// Directed-vector bench for adder4_seq with NIBBLES=4; subtract cases built with ADDSEQ_SUB_EN.
module tb_adder4_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n, start, cin;
    logic [W-1:0] A, B, S;
    logic         busy, done, cout;
`ifdef ADDSEQ_SUB_EN
    logic         sub;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder4_seq #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .cin   (cin),
`ifdef ADDSEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .S     (S),
        .cout  (cout)
    );

    // Drive a one-cycle start from a negedge; returns at the negedge after the accept edge.
    task automatic apply_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        start = 1'b1;
        A     = a;
        B     = b;
        cin   = ci;
`ifdef ADDSEQ_SUB_EN
        sub   = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A     = 16'hDEAD;
        B     = 16'hBEEF;
        cin   = ~ci;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (S !== 16'h0000) begin n_err++; $display("FAIL reset_S got %h want 0000", S); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", cout); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        apply_start(16'h1234, 16'h0FFF, 1'b0);
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL basic_accept busy=%b done=%b want 1/0", busy, done); end
        @(negedge clk);
        n_cmp++; if (S !== 16'h0003) begin n_err++; $display("FAIL basic_nib0 got %h want 0003", S); end
        @(negedge clk);
        n_cmp++; if (S !== 16'h0033) begin n_err++; $display("FAIL basic_nib1 got %h want 0033", S); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL basic_mid busy=%b done=%b want 1/0", busy, done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL basic_done done=%b busy=%b want 1/0", done, busy); end
        n_cmp++; if (S !== 16'h2233 || cout !== 1'b0) begin n_err++; $display("FAIL basic_result got %b_%h want 0_2233", cout, S); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || S !== 16'h2233) begin n_err++; $display("FAIL basic_hold done=%b S=%h want 0/2233", done, S); end
    endtask

    task automatic test_ripple();
        apply_start(16'hFFFF, 16'h0000, 1'b1);
        @(negedge clk);
        n_cmp++; if (S !== 16'h0000 || done !== 1'b0) begin n_err++; $display("FAIL ripple_mid1 S=%h done=%b want 0000/0", S, done); end
        @(negedge clk);
        n_cmp++; if (S !== 16'h0000 || done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL ripple_mid2 S=%h done=%b busy=%b want 0000/0/1", S, done, busy); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || S !== 16'h0000 || cout !== 1'b1) begin n_err++; $display("FAIL ripple_done done=%b got %b_%h want 1 1_0000", done, cout, S); end
    endtask

    task automatic test_ignore_start();
        int         pulses = 0;
        logic [W-1:0] s_at_done = '0;
        apply_start(16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        start = 1'b1;
        A     = 16'h1111;
        B     = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                s_at_done = S;
            end
        end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
        n_cmp++; if (s_at_done !== 16'h0002) begin n_err++; $display("FAIL ignore_result got %h want 0002", s_at_done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_idle busy=%b want 0", busy); end
    endtask

    task automatic test_reset_midrun();
        int  pulses = 0;
        bit  seen = 0;
        apply_start(16'h1234, 16'h0FFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rstmid_ctrl busy=%b done=%b want 0/0", busy, done); end
        n_cmp++; if (S !== 16'h0000 || cout !== 1'b0) begin n_err++; $display("FAIL rstmid_data got %b_%h want 0_0000", cout, S); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rstmid_nodone got %0d pulses want 0", pulses); end
        apply_start(16'h0003, 16'h0004, 1'b0);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL rstmid_restart_timeout got no done want done"); end
        n_cmp++; if (S !== 16'h0007 || cout !== 1'b0) begin n_err++; $display("FAIL rstmid_restart got %b_%h want 0_0007", cout, S); end
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        bit early = 0;
        apply_start(16'h00FF, 16'h0001, 1'b0);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL b2b_first_timeout got no done want done"); end
        n_cmp++; if (S !== 16'h0100 || cout !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_first got %b_%h busy=%b want 0_0100 busy=0", cout, S, busy); end
        apply_start(16'h8000, 16'h8000, 1'b0);
        n_cmp++; if (busy !== 1'b1 || S !== 16'h0000 || done !== 1'b0) begin n_err++; $display("FAIL b2b_accept busy=%b S=%h done=%b want 1/0000/0", busy, S, done); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0) early = 1;
        end
        n_cmp++; if (early) begin n_err++; $display("FAIL b2b_early got done=1 want 0 before edge k+4"); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || S !== 16'h0000 || cout !== 1'b1) begin n_err++; $display("FAIL b2b_second done=%b got %b_%h want 1 1_0000", done, cout, S); end
        @(negedge clk);
    endtask

`ifdef ADDSEQ_SUB_EN
    task automatic test_sub();
        logic [W-1:0] av [2] = '{16'h0005, 16'h0007};
        logic [W-1:0] bv [2] = '{16'h0007, 16'h0005};
        logic [W-1:0] sv [2] = '{16'hFFFE, 16'h0002};
        logic         cv [2] = '{1'b0, 1'b1};
        for (int t = 0; t < 2; t++) begin
            bit seen = 0;
            start = 1'b1;
            A     = av[t];
            B     = bv[t];
            cin   = 1'b0;
            sub   = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            sub   = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (done === 1'b1) seen = 1;
            end
            n_cmp++; if (!seen) begin n_err++; $display("FAIL sub%0d_timeout got no done want done", t); end
            n_cmp++; if (S !== sv[t] || cout !== cv[t]) begin n_err++; $display("FAIL sub%0d got %b_%h want %b_%h", t, cout, S, cv[t], sv[t]); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        cin   = 1'b0;
`ifdef ADDSEQ_SUB_EN
        sub   = 1'b0;
`endif
        test_reset();
        test_basic();
        test_ripple();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
`ifdef ADDSEQ_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
